count_capture_fifo: RTL and testbench
=====================================

COUNT_CAPTURE_FIFO -- requirements
Module: count_capture_fifo

Interface
REQ-001 The block SHALL have parameter COUNT_WD, default 16, giving the width of the sampled counter value.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the FIFO entry count; legal values are powers of two, 2 or greater.
REQ-003 The block SHALL have port i_clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port i_rstb, input, 1 bit, a synchronous active-low reset.
REQ-005 The block SHALL have port i_count, input, COUNT_WD bits, the live value from the upstream counter's o_count.
REQ-006 The block SHALL have port i_capture, input, 1 bit, a capture request that is sampled every cycle.
REQ-007 The block SHALL have port i_ready, input, 1 bit, the consumer ready signal.
REQ-008 The block SHALL have port i_clr_ovf, input, 1 bit, which clears the overflow flag.
REQ-009 The block SHALL have port o_valid, output, 1 bit, which is high when the head entry is valid.
REQ-010 The block SHALL have port o_count, output, COUNT_WD bits, the captured count at the head entry.
REQ-011 The block SHALL have port o_delta, output, COUNT_WD bits, the head entry's count minus the previous accepted capture.
REQ-012 The block SHALL have port o_level, output, $clog2(DEPTH+1) bits, the number of occupied entries.
REQ-013 The block SHALL have ports o_full and o_empty, outputs, 1 bit each, giving occupancy status.
REQ-014 The block SHALL have port o_overflow, output, 1 bit, a sticky flag for a dropped capture.

Function
REQ-015 A capture SHALL be accepted on a clock edge when i_capture=1 and either the FIFO is not full or a pop occurs on the same edge.
REQ-016 An accepted capture SHALL store i_count as sampled on that edge, with delta = i_count - prev_count computed modulo 2^COUNT_WD.
REQ-017 prev_count SHALL update to i_count only on an accepted capture, and dropped captures SHALL NOT update it.
REQ-018 The FIFO SHALL be first-word-fall-through: o_valid = !o_empty, and o_count and o_delta present the head entry combinationally from storage.
REQ-019 A pop SHALL occur on an edge where o_valid=1 and i_ready=1, and the head SHALL advance by one entry.
REQ-020 When empty, i_ready SHALL have no effect; o_count and o_delta hold their last head value and are don't-care while o_valid=0.
REQ-021 Write latency SHALL be 1 cycle: a capture accepted at edge N gives o_valid=1 after edge N when the FIFO was empty.
REQ-022 Simultaneous push and pop SHALL leave o_level unchanged, in every state including full.
REQ-023 o_level SHALL equal pushes minus pops; o_full = (o_level==DEPTH) and o_empty = (o_level==0).
REQ-024 Read and write pointers SHALL wrap from DEPTH-1 to 0 without loss or duplication of entries.
REQ-025 A capture while full with no pop on the same edge SHALL be dropped, and o_overflow SHALL be set to 1 on that edge.
REQ-026 o_overflow SHALL hold at 1 until an edge with i_clr_ovf=1; if a drop and i_clr_ovf coincide, the set SHALL win.
REQ-027 The count path SHALL need no special wrap handling, e.g. prev=0xFFFE, capture 0x0001 gives delta 0x0003.

Reset
REQ-028 On an edge where i_rstb=0, the block SHALL set pointers, o_level and prev_count to 0, o_valid=0, o_empty=1, o_full=0 and o_overflow=0.
REQ-029 On an edge where i_rstb=0, o_count and o_delta SHALL read 0, which requires storage or the output mux to be cleared.
REQ-030 Reset SHALL take priority over capture, pop and clear on the same edge; entries in flight SHALL be discarded.
REQ-031 The first edge with i_rstb=1 SHALL operate normally, with no dead cycle.

Verification
REQ-032 Reset then capture counts 10, 15, 40 with i_ready=0 -> o_level=3, head count=10, delta=10, then 5, then 25 on successive pops.
REQ-033 Fill to DEPTH=4, then a capture with i_ready=0 -> o_overflow=1, o_level=4, the dropped value is never output, and the next accepted delta is relative to the 4th entry.
REQ-034 Full, with i_capture=1 and i_ready=1 on the same edge -> o_level stays 4, the head advances, the new value is stored at the tail and o_overflow stays 0.
REQ-035 A down-counting source 0x0002, 0x0000, 0xFFFE (COUNT_WD=16) -> deltas 0x0002, 0xFFFE, 0xFFFE.
REQ-036 i_rstb=0 for one edge with o_level=3 and o_overflow=1 -> o_level=0, o_empty=1, o_overflow=0, and the next capture of 7 gives delta 7.
REQ-037 Streaming with i_capture=1 and i_ready=1 every cycle for 20 cycles -> o_level never exceeds 1, no overflow, and output order matches input order.

Source files
------------

// File: rtl/count_capture_fifo.sv
// count_capture_fifo: samples a free-running counter on capture requests and
// queues each sample with its delta from the previous accepted sample in a
// first-word-fall-through FIFO. A capture that finds the FIFO full with no
// pop on the same edge is dropped and sets a sticky overflow flag.
module count_capture_fifo #(
    parameter int COUNT_WD = 16,
    parameter int DEPTH    = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rstb,
    input  logic [COUNT_WD-1:0]          i_count,
    input  logic                         i_capture,
    input  logic                         i_ready,
    input  logic                         i_clr_ovf,
    output logic                         o_valid,
    output logic [COUNT_WD-1:0]          o_count,
    output logic [COUNT_WD-1:0]          o_delta,
    output logic [$clog2(DEPTH+1)-1:0]   o_level,
    output logic                         o_full,
    output logic                         o_empty,
    output logic                         o_overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH+1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [COUNT_WD-1:0] cnt_mem [DEPTH];
    logic [COUNT_WD-1:0] dlt_mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [LVL_W-1:0]    level;
    logic [COUNT_WD-1:0] prev_count;
    logic                overflow;

    logic                full;
    logic                empty;
    logic                pop;
    logic                push;
    logic                drop;
    logic [COUNT_WD-1:0] delta;

    // Handshake decode: a pop frees a slot for a push on the same edge.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        full  = 1'b0;
        empty = 1'b0;
        pop   = 1'b0;
        push  = 1'b0;
        drop  = 1'b0;
        delta = '0;
        full  = (level == FULL_LVL);
        empty = (level == '0);
        pop   = !empty && i_ready;
        push  = i_capture && (!full || pop);
        drop  = i_capture && !push;
        // Modulo subtraction handles counter wrap in either direction.
        delta = i_count - prev_count;
    end

    // Entry storage; cleared on reset so the head reads zero afterwards.
    always_ff @(posedge i_clk) begin
        if (!i_rstb) begin
            // NOTE: storage is reset here only because the head output must
            // read 0 after reset; plain FIFO storage would normally be left
            // unreset.
            for (int i = 0; i < DEPTH; i++) begin
                cnt_mem[i] <= '0;
                dlt_mem[i] <= '0;
            end
        end else if (push) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            cnt_mem[wr_ptr] <= i_count;
            dlt_mem[wr_ptr] <= delta;
        end
    end

    // Pointers, occupancy and the reference for the next delta.
    always_ff @(posedge i_clk) begin
        if (!i_rstb) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            prev_count <= '0;
        end else begin
            // Power-of-two depth lets the pointers wrap naturally.
            if (push) begin
                wr_ptr     <= wr_ptr + PTR_W'(1);
                prev_count <= i_count;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Sticky overflow: a drop on the same edge as a clear keeps it set.
    always_ff @(posedge i_clk) begin
        if (!i_rstb) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (i_clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    assign o_valid    = !empty;
    assign o_count    = cnt_mem[rd_ptr];
    assign o_delta    = dlt_mem[rd_ptr];
    assign o_level    = level;
    assign o_full     = full;
    assign o_empty    = empty;
    assign o_overflow = overflow;

endmodule

// File: tb/tb_count_capture_fifo.sv
// Bench for count_capture_fifo (COUNT_WD=16, DEPTH=4). A queue holds the
// expected {count, delta} entries, pushed when a capture is driven and popped
// and compared when the bench pops the DUT head.
module tb_count_capture_fifo;

    localparam int COUNT_WD = 16;
    localparam int DEPTH    = 4;

    typedef struct packed {
        logic [COUNT_WD-1:0] count;
        logic [COUNT_WD-1:0] delta;
    } entry_t;

    logic                clk;
    logic                rstb;
    logic [COUNT_WD-1:0] count_in;
    logic                capture;
    logic                ready;
    logic                clr_ovf;
    logic                valid;
    logic [COUNT_WD-1:0] count_out;
    logic [COUNT_WD-1:0] delta_out;
    logic [2:0]          level;
    logic                full;
    logic                empty;
    logic                overflow;

    entry_t              sb [$];
    logic [COUNT_WD-1:0] m_prev;
    int                  vectors;
    int                  miscompares;

    count_capture_fifo #(.COUNT_WD(COUNT_WD), .DEPTH(DEPTH)) dut (
        .i_clk      (clk),
        .i_rstb     (rstb),
        .i_count    (count_in),
        .i_capture  (capture),
        .i_ready    (ready),
        .i_clr_ovf  (clr_ovf),
        .o_valid    (valid),
        .o_count    (count_out),
        .o_delta    (delta_out),
        .o_level    (level),
        .o_full     (full),
        .o_empty    (empty),
        .o_overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one edge's inputs after the falling edge, pops the scoreboard
    // when a pop is expected (comparing the head before the edge), and returns
    // #1 after the rising edge.
    task automatic step(input logic r, input logic cap, input logic [COUNT_WD-1:0] cnt,
                        input logic rdy, input logic clr);
        int     pre_size;
        logic   m_pop;
        logic   m_push;
        entry_t e;
        @(negedge clk);
        rstb     = r;
        capture  = cap;
        count_in = cnt;
        ready    = rdy;
        clr_ovf  = clr;
        #1;
        if (!r) begin
            sb.delete();
            m_prev = '0;
        end else begin
            pre_size = sb.size();
            m_pop    = (pre_size > 0) && rdy;
            m_push   = cap && ((pre_size < DEPTH) || m_pop);
            if (m_pop) begin
                e = sb.pop_front();
                vectors++;
                if (count_out !== e.count || delta_out !== e.delta) begin
                    miscompares++;
                    $display("FAIL head: got count=%h delta=%h, expected count=%h delta=%h",
                             count_out, delta_out, e.count, e.delta);
                end
            end
            if (m_push) begin
                e.count = cnt;
                e.delta = cnt - m_prev;
                sb.push_back(e);
                m_prev = cnt;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (sb.size() > 0) step(1'b1, 1'b0, '0, 1'b1, 1'b0);
        end
        vectors++;
        if (empty !== 1'b1 || valid !== 1'b0 || level !== 3'd0) begin
            miscompares++;
            $display("FAIL drain: got empty=%b valid=%b level=%0d, expected 1 0 0",
                     empty, valid, level);
        end
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1, 16'h1234, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        vectors++;
        if (level !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || valid !== 1'b0 ||
            overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_status: got level=%0d empty=%b full=%b valid=%b ovf=%b, expected 0 1 0 0 0",
                     level, empty, full, valid, overflow);
        end
        vectors++;
        if (count_out !== 16'h0 || delta_out !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_head: got count=%h delta=%h, expected 0000 0000",
                     count_out, delta_out);
        end
    endtask

    task automatic test_basic();
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        // First capture right after reset release: no dead cycle, 1-cycle latency.
        step(1'b1, 1'b1, 16'd10, 1'b0, 1'b0);
        vectors++;
        if (valid !== 1'b1 || count_out !== 16'd10 || delta_out !== 16'd10) begin
            miscompares++;
            $display("FAIL first_capture: got valid=%b count=%0d delta=%0d, expected 1 10 10",
                     valid, count_out, delta_out);
        end
        step(1'b1, 1'b1, 16'd15, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'd40, 1'b0, 1'b0);
        vectors++;
        if (level !== 3'd3 || full !== 1'b0 || empty !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_level: got level=%0d full=%b empty=%b, expected 3 0 0",
                     level, full, empty);
        end
        drain();
    endtask

    task automatic test_overflow();
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'd1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'd2, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'd3, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'd4, 1'b0, 1'b0);
        vectors++;
        if (level !== 3'd4 || full !== 1'b1 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL fill: got level=%0d full=%b ovf=%b, expected 4 1 0", level, full, overflow);
        end
        step(1'b1, 1'b1, 16'd99, 1'b0, 1'b0);
        vectors++;
        if (level !== 3'd4 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL drop: got level=%0d ovf=%b, expected 4 1", level, overflow);
        end
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_sticky: got ovf=%b, expected 1", overflow);
        end
        // Drop and clear on the same edge: set wins.
        step(1'b1, 1'b1, 16'd77, 1'b0, 1'b1);
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_set_wins: got ovf=%b, expected 1", overflow);
        end
        step(1'b1, 1'b0, '0, 1'b0, 1'b1);
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clear: got ovf=%b, expected 0", overflow);
        end
        // Next accepted delta is relative to the 4th entry (4), not 99 or 77.
        step(1'b1, 1'b1, 16'd100, 1'b1, 1'b0);
        drain();
    endtask

    task automatic test_full_push_pop();
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'd10, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'd20, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'd30, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'd40, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'd55, 1'b1, 1'b0);
        vectors++;
        if (level !== 3'd4 || full !== 1'b1 || overflow !== 1'b0 || count_out !== 16'd20) begin
            miscompares++;
            $display("FAIL full_push_pop: got level=%0d full=%b ovf=%b head=%0d, expected 4 1 0 20",
                     level, full, overflow, count_out);
        end
        drain();
    endtask

    task automatic test_down_count();
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h0002, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h0000, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        vectors++;
        if (delta_out !== 16'h0002) begin
            miscompares++;
            $display("FAIL down_first_delta: got %h, expected 0002", delta_out);
        end
        drain();
        // Upward wrap: prev=FFFE, capture 0001 -> delta 0003.
        step(1'b1, 1'b1, 16'h0001, 1'b0, 1'b0);
        vectors++;
        if (delta_out !== 16'h0003) begin
            miscompares++;
            $display("FAIL wrap_delta: got %h, expected 0003", delta_out);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b1, 16'(i * 100), 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b1, 1'b0);
        vectors++;
        if (level !== 3'd3 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset: got level=%0d ovf=%b, expected 3 1", level, overflow);
        end
        // Reset beats capture, pop and clear on the same edge.
        step(1'b0, 1'b1, 16'd999, 1'b1, 1'b1);
        vectors++;
        if (level !== 3'd0 || empty !== 1'b1 || overflow !== 1'b0 || count_out !== 16'd0 ||
            delta_out !== 16'd0) begin
            miscompares++;
            $display("FAIL mid_reset: got level=%0d empty=%b ovf=%b count=%0d delta=%0d, expected 0 1 0 0 0",
                     level, empty, overflow, count_out, delta_out);
        end
        step(1'b1, 1'b1, 16'd7, 1'b0, 1'b0);
        vectors++;
        if (valid !== 1'b1 || count_out !== 16'd7 || delta_out !== 16'd7) begin
            miscompares++;
            $display("FAIL post_reset_capture: got valid=%b count=%0d delta=%0d, expected 1 7 7",
                     valid, count_out, delta_out);
        end
        drain();
    endtask

    task automatic test_stream();
        logic [COUNT_WD-1:0] c;
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        c = 16'hFF00;
        for (int i = 0; i < 20; i++) begin
            c = c + 16'($urandom_range(1, 40));
            step(1'b1, 1'b1, c, 1'b1, 1'b0);
            vectors++;
            if (level !== 3'd1 || overflow !== 1'b0) begin
                miscompares++;
                $display("FAIL stream[%0d]: got level=%0d ovf=%b, expected 1 0", i, level, overflow);
            end
        end
        drain();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_prev      = '0;
        rstb        = 1'b0;
        capture     = 1'b0;
        count_in    = '0;
        ready       = 1'b0;
        clr_ovf     = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_down_count();
        test_reset_mid();
        test_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
